gpio_apb_arbiter: RTL and testbench
===================================

# gpio_apb_arbiter

Round-robin APB3 master that shares one CoreGPIO slave port among several on-chip requesters, such as firmware-mailbox, EMG-sampling sequencer and debug logic. Each requester posts a single read or write command for a CoreGPIO register (IN/OUT/INT/OE/CONFIG). The arbiter grants one command at a time and runs the APB SETUP/ACCESS phases, honouring PREADY. It returns read data and error status to the winner. The block sits between the requesters and the CoreGPIO PSEL/PENABLE/PADDR/PWDATA/PRDATA port.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- APB_WIDTH, 32, data width, matches CoreGPIO APB_WIDTH (8/16/32)
- TIMEOUT, 255, max ACCESS cycles waiting for PREADY; 0 disables timeout
- PCLK  in  1  clock; all logic on rising edge
- PRESETN  in  1  reset, synchronous, active-low
- REQ  in  NUM_REQ  per-requester command valid; held until matching DONE
- REQ_WRITE  in  NUM_REQ  1 = write, 0 = read
- REQ_ADDR  in  NUM_REQ*8  register address, requester i at [8i+7:8i]
- REQ_WDATA  in  NUM_REQ*APB_WIDTH  write data, requester i at slice i
- DONE  out  NUM_REQ  one-hot, 1-cycle completion pulse
- RSP_RDATA  out  APB_WIDTH  captured PRDATA, valid with DONE; 0 for writes
- RSP_ERR  out  1  PSLVERR or timeout, valid with DONE
- PSEL, PENABLE, PWRITE  out  1 each  APB master controls
- PADDR  out  8  APB address
- PWDATA  out  APB_WIDTH  APB write data
- PRDATA  in  APB_WIDTH  APB read data
- PREADY, PSLVERR  in  1 each  APB slave response

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: if any REQ is high, pick the winner by round-robin search starting at (last_grant+1) mod NUM_REQ.
  - Latch the winner index and its WRITE/ADDR/WDATA.
  - Go to SETUP. With no REQ high, stay in IDLE.
- SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA from the latched command. Go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1, address, control and data unchanged. The timeout counter increments each cycle.
  - PREADY=1: capture PRDATA (reads only) and PSLVERR, then go to RESP.
  - Counter reaches TIMEOUT with TIMEOUT≠0 and PREADY still 0: abort. RSP_ERR=1, RSP_RDATA=0, go to RESP.
- RESP: PSEL=PENABLE=0. DONE[winner]=1, RSP_RDATA and RSP_ERR valid. Update last_grant to the winner, go to IDLE.
  - The requester drops or replaces REQ on the edge leaving RESP.
  - REQ is not sampled during RESP.
- Command inputs are sampled only in IDLE. A REQ drop after the latch does not abort the transfer; DONE still pulses.
- Simultaneous REQs are served strictly in rotation. A requester holding REQ continuously is served again only after every other pending requester.
- Outside SETUP/ACCESS: PSEL=PENABLE=0, PADDR/PWDATA/PWRITE hold their last value.

## Timing
- Reset (PRESETN low at an edge) sets:
  - state to IDLE;
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, DONE, RSP_RDATA and RSP_ERR to 0;
  - last_grant to NUM_REQ-1, so requester 0 has first priority.
- Reset mid-transfer drops PSEL/PENABLE at that edge and produces no DONE.
- REQ seen high in IDLE at edge k gives:
  - PSEL=1 in cycle k+1 (SETUP);
  - PENABLE=1 in cycle k+2;
  - with PREADY=1 in k+2, DONE in k+3 and IDLE in k+4.
- Zero-wait throughput is 4 cycles per transfer. Each PREADY-low cycle adds 1 cycle.
- With a timeout, the abort occurs after exactly TIMEOUT ACCESS cycles with PREADY=0. DONE follows on the next cycle.
- PADDR, PWRITE and PWDATA are stable from SETUP through the last ACCESS cycle.

## Test plan
- Single write: REQ[0]=1, ADDR=0x01, WDATA=0x5A, PREADY tied 1. Expect PSEL at k+1, PENABLE at k+2, DONE[0] at k+3 with RSP_ERR=0, and GPIO_OUT=0x5A.
- Read with wait states: REQ[2] reads ADDR=0x00, slave holds PREADY=0 for 3 cycles, then PRDATA=0x0000_00C3. Expect 4 ACCESS cycles, DONE[2] with RSP_RDATA=0xC3, and PADDR stable throughout.
- Round-robin: REQ=4'b1111 held and re-asserted after each DONE. Expect grant order 0,1,2,3,0 and no requester served twice in a row while others pend.
- Error and timeout:
  - PSLVERR=1 with PREADY=1 gives DONE with RSP_ERR=1.
  - With TIMEOUT=4 and PREADY stuck 0, expect abort after 4 ACCESS cycles, RSP_ERR=1, RSP_RDATA=0.
- Reset mid-ACCESS: drive PRESETN=0 during a wait state. Expect all outputs 0 at that edge and no DONE. After release, REQ[1] is served before REQ[3].

Source files
------------

// File: rtl/gpio_apb_arbiter.sv
// gpio_apb_arbiter: round-robin APB3 master that shares one CoreGPIO slave port among NUM_REQ requesters
module gpio_apb_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int APB_WIDTH = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                         PCLK,
    input  logic                         PRESETN,
    input  logic [NUM_REQ-1:0]           REQ,
    input  logic [NUM_REQ-1:0]           REQ_WRITE,
    input  logic [NUM_REQ*8-1:0]         REQ_ADDR,
    input  logic [NUM_REQ*APB_WIDTH-1:0] REQ_WDATA,
    output logic [NUM_REQ-1:0]           DONE,
    output logic [APB_WIDTH-1:0]         RSP_RDATA,
    output logic                         RSP_ERR,
    output logic                         PSEL,
    output logic                         PENABLE,
    output logic                         PWRITE,
    output logic [7:0]                   PADDR,
    output logic [APB_WIDTH-1:0]         PWDATA,
    input  logic [APB_WIDTH-1:0]         PRDATA,
    input  logic                         PREADY,
    input  logic                         PSLVERR
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        grant_q, grant_d, last_q, last_d, win, idx;
    logic                 found, expired;
    logic                 pwrite_q, pwrite_d, err_q, err_d;
    logic [7:0]           paddr_q, paddr_d;
    logic [APB_WIDTH-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
    logic [TW-1:0]        cnt_q, cnt_d;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("gpio_apb_arbiter: NUM_REQ must be 2..8");
    end
    if (APB_WIDTH != 8 && APB_WIDTH != 16 && APB_WIDTH != 32) begin : g_bad_width
        $error("gpio_apb_arbiter: APB_WIDTH must be 8, 16 or 32");
    end

    // Walk offsets from the far end so the requester nearest last_q+1 is assigned last and wins.
    always_comb begin
        win   = last_q;
        idx   = last_q;
        found = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = IW'((int'(last_q) + i) % NUM_REQ);
            if (REQ[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign expired = (TIMEOUT != 0) && (int'(cnt_q) + 1 >= TIMEOUT);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d  = SETUP;
                    grant_d  = win;
                    pwrite_d = REQ_WRITE[win];
                    paddr_d  = REQ_ADDR[int'(win)*8 +: 8];
                    pwdata_d = REQ_WDATA[int'(win)*APB_WIDTH +: APB_WIDTH];
                    cnt_d    = '0;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    state_d = RESP;
                    rdata_d = pwrite_q ? '0 : PRDATA;
                    err_d   = PSLVERR;
                end else if (expired) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                last_d  = grant_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            last_q   <= IW'(NUM_REQ - 1);
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign PSEL      = (state_q == SETUP) || (state_q == ACCESS);
    assign PENABLE   = state_q == ACCESS;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign RSP_RDATA = rdata_q;
    assign RSP_ERR   = err_q;
    assign DONE      = (state_q == RESP) ? NUM_REQ'(1) << grant_q : '0;
endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// tb_gpio_apb_arbiter: directed and random traffic against a cycle-timeline model of the arbiter and a register-file slave
module tb_gpio_apb_arbiter;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 4;

    logic           PCLK = 1'b0, PRESETN = 1'b0;
    logic [N-1:0]   REQ = '0, REQ_WRITE = '0;
    logic [N*8-1:0] REQ_ADDR = '0;
    logic [N*W-1:0] REQ_WDATA = '0;
    logic [N-1:0]   DONE;
    logic [W-1:0]   RSP_RDATA, PWDATA;
    logic [W-1:0]   PRDATA = '0;
    logic           RSP_ERR, PSEL, PENABLE, PWRITE;
    logic           PREADY = 1'b0, PSLVERR = 1'b0;
    logic [7:0]     PADDR;

    gpio_apb_arbiter #(.NUM_REQ(N), .APB_WIDTH(W), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .REQ(REQ), .REQ_WRITE(REQ_WRITE),
        .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .DONE(DONE),
        .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int total = 0, bad = 0;
    logic [W-1:0] smem [256];
    logic [W-1:0] mmem [256];
    int dq[$];
    int acc_cnt = 0;
    int f_wait = -1, f_err = -1;
    bit keep = 0, rnd = 0;

    // Model of the transfer in flight: granted at edge t_g, t_a ACCESS cycles, DONE in cycle t_g+t_a+1.
    bit t_on = 0, t_slv, t_to, t_err, t_wr;
    int t_g, t_a, t_w, t_wait;
    int last = N - 1, next_free = 0;
    logic [7:0] t_addr;
    logic [W-1:0] t_wd, t_rd;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_cmd(input int i, input bit wr, input logic [7:0] a, input logic [W-1:0] d);
        REQ_WRITE[i]         = wr;
        REQ_ADDR[i*8 +: 8]   = a;
        REQ_WDATA[i*W +: W]  = d;
        REQ[i]               = 1'b1;
    endtask

    task automatic new_cmd(input int i);
        set_cmd(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), $urandom);
    endtask

    task automatic grant();
        int w;
        w = -1;
        for (int i = 1; i <= N; i++)
            if (w < 0 && REQ[(last + i) % N]) w = (last + i) % N;
        t_w    = w;
        t_g    = cyc + 1;
        t_wait = f_wait >= 0 ? f_wait : $urandom_range(0, 5);
        t_slv  = f_err >= 0 ? (f_err != 0) : ($urandom_range(0, 7) == 0);
        t_to   = t_wait + 1 > TO;
        t_a    = t_to ? TO : t_wait + 1;
        t_err  = t_to || t_slv;
        t_wr   = REQ_WRITE[w];
        t_addr = REQ_ADDR[w*8 +: 8];
        t_wd   = REQ_WDATA[w*W +: W];
        t_rd   = (t_to || t_wr) ? '0 : mmem[t_addr];
        if (t_wr && !t_err) mmem[t_addr] = t_wd;
        last      = w;
        next_free = t_g + t_a + 3;
        t_on      = 1;
    endtask

    task automatic step();
        logic [N-1:0] ed;
        bit sel, en;
        if (!PRESETN) begin
            t_on      = 0;
            last      = N - 1;
            next_free = cyc + 2;
        end else if (!t_on && cyc + 1 >= next_free && REQ != '0) begin
            grant();
        end
        @(negedge PCLK);
        sel = t_on && cyc >= t_g && cyc <= t_g + t_a;
        en  = t_on && cyc > t_g && cyc <= t_g + t_a;
        ed  = '0;
        if (t_on && cyc == t_g + t_a + 1) ed[t_w] = 1'b1;
        if (!PRESETN)
            check("reset_outputs", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, RSP_RDATA, RSP_ERR, DONE}, '0);
        check("psel", PSEL, sel);
        check("penable", PENABLE, en);
        check("done", DONE, ed);
        if (sel) begin
            check("paddr", PADDR, t_addr);
            check("pwrite", PWRITE, t_wr);
            check("pwdata", PWDATA, t_wd);
        end
        if (ed != '0) begin
            check("rsp_rdata", RSP_RDATA, t_rd);
            check("rsp_err", RSP_ERR, t_err);
        end
        if (PENABLE) acc_cnt++;
        for (int i = 0; i < N; i++) if (DONE[i]) dq.push_back(i);
        PREADY  = t_on && (cyc - t_g - 1 >= t_wait);
        PSLVERR = PREADY && t_slv;
        PRDATA  = PWRITE ? $urandom : smem[PADDR];
        if (PSEL && PENABLE && PREADY && !PSLVERR && PWRITE) smem[PADDR] = PWDATA;
        if (ed != '0) begin
            t_on = 0;
            if (keep || (rnd && $urandom_range(0, 1) == 1)) new_cmd(t_w);
            else REQ[t_w] = 1'b0;
        end
        if (rnd) begin
            for (int i = 0; i < N; i++) begin
                if (t_on && i == t_w) begin
                    if (REQ[i] && $urandom_range(0, 15) == 0) REQ[i] = 1'b0;
                end else if (!REQ[i] && $urandom_range(0, 3) == 0) begin
                    new_cmd(i);
                end
            end
            PRESETN = ($urandom_range(0, 399) != 0);
        end
    endtask

    task automatic wait_done(input int max);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (DONE == '0 && n < max);
        check("done_wait", |DONE, 1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((REQ != '0 || t_on) && n < 500) begin
            step();
            n++;
        end
        check("drain", |REQ, 1'b0);
        repeat (3) step();
    endtask

    initial begin
        int n;
        int rr[5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 256; i++) begin
            smem[i] = $urandom;
            mmem[i] = smem[i];
        end
        smem[0] = 32'h0000_00C3;
        mmem[0] = 32'h0000_00C3;
        repeat (3) step();
        PRESETN = 1'b1;

        f_wait = 0; f_err = 0;
        set_cmd(0, 1'b1, 8'h01, 32'h5A);
        wait_done(20);
        check("write_done0", DONE, 4'b0001);
        check("write_err", RSP_ERR, 1'b0);
        check("gpio_out", smem[1], 32'h5A);

        f_wait = 3; acc_cnt = 0;
        set_cmd(2, 1'b0, 8'h00, 32'h1234_5678);
        wait_done(20);
        check("read_done2", DONE, 4'b0100);
        check("read_rdata", RSP_RDATA, 32'hC3);
        check("read_access_cycles", acc_cnt, 4);

        f_wait = 0; f_err = 1;
        set_cmd(1, 1'b1, 8'h03, 32'hDEAD_BEEF);
        wait_done(20);
        check("slverr_err", RSP_ERR, 1'b1);

        f_wait = 50; f_err = 0; acc_cnt = 0;
        set_cmd(3, 1'b0, 8'h02, 32'h0);
        wait_done(30);
        check("timeout_err", RSP_ERR, 1'b1);
        check("timeout_rdata", RSP_RDATA, 32'h0);
        check("timeout_access_cycles", acc_cnt, TO);
        repeat (2) step();

        PRESETN = 1'b0;
        repeat (2) step();
        PRESETN = 1'b1;
        f_wait = 0; f_err = 0; keep = 1; dq.delete();
        for (int i = 0; i < N; i++) new_cmd(i);
        repeat (5) wait_done(30);
        keep = 0;
        check("rr_count", dq.size(), 5);
        for (int k = 0; k < 5 && k < dq.size(); k++) check("rr_order", dq[k], rr[k]);
        drain();

        f_wait = 50;
        set_cmd(0, 1'b0, 8'h04, 32'h0);
        n = 0;
        do begin
            step();
            n++;
        end while (!PENABLE && n < 20);
        check("access_seen", PENABLE, 1'b1);
        step();
        new_cmd(1);
        new_cmd(3);
        REQ[0] = 1'b0;
        PRESETN = 1'b0;
        dq.delete();
        step();
        PRESETN = 1'b1;
        f_wait = 0;
        wait_done(20);
        wait_done(20);
        check("post_reset_count", dq.size(), 2);
        if (dq.size() >= 2) begin
            check("post_reset_first", dq[0], 1);
            check("post_reset_second", dq[1], 3);
        end
        drain();

        f_wait = -1; f_err = -1; rnd = 1;
        repeat (3000) step();
        rnd = 0;
        PRESETN = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
